// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator with a main + skid output buffer.
// Optional per-type handshake counters under IMM_GEN_PIPE_STATS_EN.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immediate_value,
    output logic [2:0]      imm_type
`ifdef IMM_GEN_PIPE_STATS_EN
    ,
    input  logic            stat_clr,
    input  logic [2:0]      stat_sel,
    output logic [31:0]     stat_count
`endif
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_Z    = 3'd6;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic            w_sign;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_accept;
    logic            w_drain;

    logic            r_valid;
    logic [XLEN-1:0] r_imm;
    logic [2:0]      r_type;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_type;

    assign w_sign = instruction[31];

    // Fill with the sign first, then overwrite the low field bits.
    always_comb begin
        w_imm  = {XLEN{w_sign}};
        w_type = T_NONE;
        case (instruction[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                w_type      = T_I;
                w_imm[11:0] = instruction[31:20];
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    w_type      = T_I;
                    w_imm[11:0] = instruction[31:20];
                end
            end
            7'b0100011: begin
                w_type      = T_S;
                w_imm[11:0] = {instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                w_type      = T_B;
                w_imm[12:0] = {instruction[31], instruction[7],
                               instruction[30:25], instruction[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_type      = T_U;
                w_imm[31:0] = {instruction[31:12], 12'b0};
            end
            7'b1101111: begin
                w_type      = T_J;
                w_imm[20:0] = {instruction[31], instruction[19:12],
                               instruction[20], instruction[30:21], 1'b0};
            end
            7'b1110011: begin
                if (instruction[14]) begin
                    w_type = T_Z;
                end
            end
            default: ;
        endcase
        if (w_type == T_NONE) begin
            w_imm = '0;
        end else if (w_type == T_Z) begin
            w_imm      = '0;
            w_imm[4:0] = instruction[19:15];
        end
    end

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && !r_skid_valid;
    assign w_drain  = !r_valid || out_ready;

    // The skid only fills while the main register is stalled, and drains first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_imm        <= '0;
            r_type       <= T_NONE;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_type  <= T_NONE;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_valid      <= 1'b1;
                r_imm        <= r_skid_imm;
                r_type       <= r_skid_type;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_imm   <= w_imm;
                r_type  <= w_type;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_type  <= w_type;
        end
    end

    assign out_valid       = r_valid;
    assign immediate_value = r_imm;
    assign imm_type        = r_type;

`ifdef IMM_GEN_PIPE_STATS_EN
    logic [31:0] r_cnt [7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
        end else if (stat_clr) begin
            for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
        end else if (r_valid && out_ready) begin
            for (int i = 0; i < 7; i++) begin
                if (r_type == 3'(i) && r_cnt[i] != 32'hFFFF_FFFF) begin
                    r_cnt[i] <= r_cnt[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < 7; i++) begin
            if (stat_sel == 3'(i)) stat_count = r_cnt[i];
        end
    end
`endif

endmodule
